// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the 8-bit CPU (ALU ops, bus selects, CCR bits, opcodes).
// Latency: none (constants, types and one pure function).
// Backpressure: none.
package cpu_pkg;

   localparam int DATA_W = 8;

   // ALU operation select
   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_INC = 3'b001,
      ALU_SUB = 3'b010,
      ALU_AND = 3'b011,
      ALU_OR  = 3'b100,
      ALU_XOR = 3'b101,
      ALU_DEC = 3'b110,
      ALU_NOT = 3'b111
   } alu_sel_t;

   // Bus1 sources
   localparam logic [1:0] BUS1_PC   = 2'b00;
   localparam logic [1:0] BUS1_A    = 2'b01;
   localparam logic [1:0] BUS1_B    = 2'b10;
   localparam logic [1:0] BUS1_ZERO = 2'b11;

   // Bus2 sources
   localparam logic [1:0] BUS2_ALU  = 2'b00;
   localparam logic [1:0] BUS2_BUS1 = 2'b01;
   localparam logic [1:0] BUS2_MEM  = 2'b10;
   localparam logic [1:0] BUS2_ZERO = 2'b11;

   // CCR bit positions within {N,Z,V,C}
   localparam int CCR_N = 3;
   localparam int CCR_Z = 2;
   localparam int CCR_V = 1;
   localparam int CCR_C = 0;

   // Opcodes decoded by control_unit
   localparam logic [7:0] OP_LDA_IMM = 8'h86;
   localparam logic [7:0] OP_LDA_DIR = 8'h87;
   localparam logic [7:0] OP_LDB_IMM = 8'h88;
   localparam logic [7:0] OP_LDB_DIR = 8'h89;
   localparam logic [7:0] OP_STA_DIR = 8'h96;
   localparam logic [7:0] OP_STB_DIR = 8'h97;
   localparam logic [7:0] OP_ADD_AB  = 8'h42;
   localparam logic [7:0] OP_SUB_AB  = 8'h43;
   localparam logic [7:0] OP_AND_AB  = 8'h44;
   localparam logic [7:0] OP_OR_AB   = 8'h45;
   localparam logic [7:0] OP_INCA    = 8'h46;
   localparam logic [7:0] OP_INCB    = 8'h47;
   localparam logic [7:0] OP_DECA    = 8'h48;
   localparam logic [7:0] OP_DECB    = 8'h49;
   localparam logic [7:0] OP_BRA     = 8'h20;
   localparam logic [7:0] OP_BMI     = 8'h21;
   localparam logic [7:0] OP_BEQ     = 8'h23;

   // Arithmetic ops are the only ones that can produce V and C
   function automatic logic is_arith(input alu_sel_t op);
      return (op == ALU_ADD) || (op == ALU_INC) || (op == ALU_SUB) || (op == ALU_DEC);
   endfunction

endpackage

// File: rtl/data_path_alu.sv
// alu: 8-bit combinational ALU with a 9-bit internal datapath and NZVC flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module alu
   import cpu_pkg::*;
(
   input  logic [7:0] X,
   input  logic [7:0] Y,
   input  logic [2:0] ALU_Sel,
   output logic [7:0] Result,
   output logic [3:0] NZVC
);

   alu_sel_t   op;
   logic [8:0] res9;
   logic       ovf;
   logic       cry;

   assign op = alu_sel_t'(ALU_Sel);

   // Compute result; bit 8 carries the carry-out (add/inc) or borrow (sub/dec)
   always_comb begin
      res9 = '0;
      ovf  = 1'b0;
      cry  = 1'b0;
      unique case (op)
         ALU_ADD: begin
            res9 = {1'b0, X} + {1'b0, Y};
            cry  = res9[8];
            ovf  = (X[7] == Y[7]) && (res9[7] != X[7]);
         end
         ALU_INC: begin
            res9 = {1'b0, X} + 9'd1;
            cry  = res9[8];
            ovf  = ~X[7] & res9[7];
         end
         ALU_SUB: begin
            res9 = {1'b0, X} - {1'b0, Y};
            cry  = res9[8];
            ovf  = (X[7] != Y[7]) && (res9[7] != X[7]);
         end
         ALU_DEC: begin
            res9 = {1'b0, X} - 9'd1;
            cry  = res9[8];
            ovf  = X[7] & ~res9[7];
         end
         ALU_AND: res9 = {1'b0, X & Y};
         ALU_OR:  res9 = {1'b0, X | Y};
         ALU_XOR: res9 = {1'b0, X ^ Y};
         ALU_NOT: res9 = {1'b0, ~X};
      endcase
   end

   assign Result = res9[7:0];
   assign NZVC   = {res9[7], (res9[7:0] == 8'h00), ovf, cry};

endmodule

// File: rtl/data_path.sv
// data_path: 8-bit CPU datapath (IR, MAR, PC, A, B, CCR), two buses and ALU; DATA_PATH_DEBUG_EN adds register taps.
// Latency: every load visible one cycle after its enabling edge; to_memory is a mux of registers only.
// Backpressure: none; control_unit drives loads directly every cycle.
module data_path
   import cpu_pkg::*;
#(
   parameter int         WIDTH    = 8,
   parameter logic [7:0] PC_RESET = 8'h00
)(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             IR_Load,
   input  logic             MAR_Load,
   input  logic             PC_Load,
   input  logic             PC_Inc,
   input  logic             A_Load,
   input  logic             B_Load,
   input  logic             CCR_Load,
   input  logic [2:0]       ALU_Sel,
   input  logic [1:0]       Bus1_Sel,
   input  logic [1:0]       Bus2_Sel,
   input  logic [WIDTH-1:0] from_memory,
   output logic [WIDTH-1:0] address,
   output logic [WIDTH-1:0] to_memory,
   output logic [WIDTH-1:0] IR,
   output logic [3:0]       CCR_Result
`ifdef DATA_PATH_DEBUG_EN
   ,
   output logic [WIDTH-1:0] dbg_PC,
   output logic [WIDTH-1:0] dbg_A,
   output logic [WIDTH-1:0] dbg_B,
   output logic [WIDTH-1:0] dbg_MAR
`endif
);

   logic [WIDTH-1:0] ir_q,  ir_d;
   logic [WIDTH-1:0] mar_q, mar_d;
   logic [WIDTH-1:0] pc_q,  pc_d;
   logic [WIDTH-1:0] a_q,   a_d;
   logic [WIDTH-1:0] b_q,   b_d;
   logic [3:0]       ccr_q, ccr_d;

   logic [WIDTH-1:0] bus1;
   logic [WIDTH-1:0] bus2;
   logic [WIDTH-1:0] alu_result;
   logic [3:0]       alu_nzvc;
   logic [3:0]       flags;
   logic             alu_on_bus2;

   // Bus1 source mux (also the memory write data)
   always_comb begin
      bus1 = '0;
      unique case (Bus1_Sel)
         BUS1_PC:   bus1 = pc_q;
         BUS1_A:    bus1 = a_q;
         BUS1_B:    bus1 = b_q;
         BUS1_ZERO: bus1 = '0;
      endcase
   end

   alu u_alu (
      .X       (bus1),
      .Y       (b_q),
      .ALU_Sel (ALU_Sel),
      .Result  (alu_result),
      .NZVC    (alu_nzvc)
   );

   // Bus2 source mux; every register load captures this value
   always_comb begin
      bus2 = '0;
      unique case (Bus2_Sel)
         BUS2_ALU:  bus2 = alu_result;
         BUS2_BUS1: bus2 = bus1;
         BUS2_MEM:  bus2 = from_memory;
         BUS2_ZERO: bus2 = '0;
      endcase
   end

   assign alu_on_bus2 = (Bus2_Sel == BUS2_ALU);

   // Flags follow Bus2; V and C only exist when an arithmetic result is on Bus2
   always_comb begin
      flags        = '0;
      flags[CCR_N] = alu_on_bus2 ? alu_nzvc[CCR_N] : bus2[WIDTH-1];
      flags[CCR_Z] = alu_on_bus2 ? alu_nzvc[CCR_Z] : (bus2 == '0);
      if (alu_on_bus2 && is_arith(alu_sel_t'(ALU_Sel))) begin
         flags[CCR_V] = alu_nzvc[CCR_V];
         flags[CCR_C] = alu_nzvc[CCR_C];
      end
   end

   // Next-state selection; PC_Load takes priority over PC_Inc
   always_comb begin
      ir_d  = IR_Load  ? bus2 : ir_q;
      mar_d = MAR_Load ? bus2 : mar_q;
      a_d   = A_Load   ? bus2 : a_q;
      b_d   = B_Load   ? bus2 : b_q;
      ccr_d = CCR_Load ? flags : ccr_q;
      pc_d  = pc_q;
      if (PC_Load)
         pc_d = bus2;
      else if (PC_Inc)
         pc_d = pc_q + WIDTH'(1);
   end

   // Register update; reset overrides any load in the same cycle
   always_ff @(posedge Clk) begin
      if (Reset) begin
         ir_q  <= '0;
         mar_q <= '0;
         pc_q  <= PC_RESET;
         a_q   <= '0;
         b_q   <= '0;
         ccr_q <= '0;
      end else begin
         ir_q  <= ir_d;
         mar_q <= mar_d;
         pc_q  <= pc_d;
         a_q   <= a_d;
         b_q   <= b_d;
         ccr_q <= ccr_d;
      end
   end

   assign address    = mar_q;
   assign to_memory  = bus1;
   assign IR         = ir_q;
   assign CCR_Result = ccr_q;

`ifdef DATA_PATH_DEBUG_EN
   assign dbg_PC  = pc_q;
   assign dbg_A   = a_q;
   assign dbg_B   = b_q;
   assign dbg_MAR = mar_q;
`endif

endmodule

// File: tb/tb_data_path.sv
// tb_data_path: directed spec vectors plus randomized control sequences against a behavioural model.
// Latency: model registers update one edge after the controls are applied.
// Backpressure: none.
module tb_data_path;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load;
   logic [2:0] ALU_Sel;
   logic [1:0] Bus1_Sel, Bus2_Sel;
   logic [7:0] from_memory;
   logic [7:0] address, to_memory, IR;
   logic [3:0] CCR_Result;

   int tests = 0;
   int fails = 0;

   // reference state
   logic [7:0] m_pc, m_a, m_b, m_ir, m_mar;
   logic [3:0] m_ccr;

   data_path dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .IR_Load     (IR_Load),
      .MAR_Load    (MAR_Load),
      .PC_Load     (PC_Load),
      .PC_Inc      (PC_Inc),
      .A_Load      (A_Load),
      .B_Load      (B_Load),
      .CCR_Load    (CCR_Load),
      .ALU_Sel     (ALU_Sel),
      .Bus1_Sel    (Bus1_Sel),
      .Bus2_Sel    (Bus2_Sel),
      .from_memory (from_memory),
      .address     (address),
      .to_memory   (to_memory),
      .IR          (IR),
      .CCR_Result  (CCR_Result)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] mbus1(input logic [1:0] sel);
      case (sel)
         2'd0:    return m_pc;
         2'd1:    return m_a;
         2'd2:    return m_b;
         default: return 8'h00;
      endcase
   endfunction

   // ALU from plain integer arithmetic: V from signed range, C from unsigned compare
   task automatic malu(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                       output logic [7:0] r, output logic v, output logic c);
      int ux, uy, sx, sy, ur, sr;
      ux = x; uy = y;
      sx = $signed(x); sy = $signed(y);
      ur = 0; sr = 0; v = 1'b0; c = 1'b0; r = 8'h00;
      case (op)
         3'd0: begin ur = ux + uy; sr = sx + sy; c = (ur > 255); end
         3'd1: begin ur = ux + 1;  sr = sx + 1;  c = (ux == 255); end
         3'd2: begin ur = ux - uy; sr = sx - sy; c = (ux < uy); end
         3'd6: begin ur = ux - 1;  sr = sx - 1;  c = (ux == 0); end
         default: ;
      endcase
      case (op)
         3'd0, 3'd1, 3'd2, 3'd6: begin
            ur = ur & 255;
            r  = ur[7:0];
            v  = (sr > 127) || (sr < -128);
         end
         3'd3: r = x & y;
         3'd4: r = x | y;
         3'd5: r = x ^ y;
         default: r = ~x;
      endcase
   endtask

   // advance one clock edge, moving the model with it
   task automatic tick();
      logic [7:0] b1, b2, r;
      logic       v, c, arith;
      logic [3:0] fl;
      b1 = mbus1(Bus1_Sel);
      malu(ALU_Sel, b1, m_b, r, v, c);
      case (Bus2_Sel)
         2'd0:    b2 = r;
         2'd1:    b2 = b1;
         2'd2:    b2 = from_memory;
         default: b2 = 8'h00;
      endcase
      arith = (Bus2_Sel == 2'd0) && (ALU_Sel inside {3'd0, 3'd1, 3'd2, 3'd6});
      fl = {b2[7], b2 == 8'h00, arith & v, arith & c};
      @(posedge Clk);
      #1;
      if (Reset) begin
         m_pc = 8'h00; m_a = 8'h00; m_b = 8'h00; m_ir = 8'h00; m_mar = 8'h00; m_ccr = 4'h0;
      end else begin
         if (IR_Load)  m_ir  = b2;
         if (MAR_Load) m_mar = b2;
         if (A_Load)   m_a   = b2;
         if (B_Load)   m_b   = b2;
         if (CCR_Load) m_ccr = fl;
         if (PC_Load)      m_pc = b2;
         else if (PC_Inc)  m_pc = m_pc + 8'd1;
      end
   endtask

   task automatic idle();
      Reset = 1'b0;
      {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load} = '0;
      ALU_Sel = 3'd0; Bus1_Sel = 2'd3; Bus2_Sel = 2'd3; from_memory = 8'h00;
   endtask

   task automatic chk_model(input string tag);
      #1;
      chk({tag, "_address"}, address, m_mar);
      chk({tag, "_IR"}, IR, m_ir);
      chk({tag, "_CCR"}, {4'h0, CCR_Result}, {4'h0, m_ccr});
      chk({tag, "_to_memory"}, to_memory, mbus1(Bus1_Sel));
   endtask

   // view a register through Bus1 / to_memory and compare against a fixed value
   task automatic peek(input string tag, input logic [1:0] sel, input logic [7:0] exp);
      Bus1_Sel = sel;
      #1;
      chk(tag, to_memory, exp);
   endtask

   task automatic load_reg(input logic [7:0] val, input bit to_a);
      idle();
      Bus2_Sel = 2'd2; from_memory = val;
      if (to_a) A_Load = 1'b1; else B_Load = 1'b1;
      tick();
      idle();
   endtask

   initial begin
      idle();
      // reset with every load asserted
      Reset = 1'b1;
      {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load} = '1;
      Bus2_Sel = 2'd2; from_memory = 8'hAA;
      tick();
      idle();
      chk("rst_IR", IR, 8'h00);
      chk("rst_address", address, 8'h00);
      chk("rst_CCR", {4'h0, CCR_Result}, 8'h00);
      peek("rst_PC", 2'd0, 8'h00);
      peek("rst_A", 2'd1, 8'h00);
      peek("rst_B", 2'd2, 8'h00);

      // fetch: MAR <= PC, then IR <= mem, PC++
      Bus1_Sel = 2'd0; Bus2_Sel = 2'd1; MAR_Load = 1'b1;
      tick(); idle();
      chk("fetch_address", address, 8'h00);
      Bus2_Sel = 2'd2; from_memory = 8'h86; IR_Load = 1'b1; PC_Inc = 1'b1;
      tick(); idle();
      chk("fetch_IR", IR, 8'h86);
      peek("fetch_PC", 2'd0, 8'h01);

      // ADD overflow
      load_reg(8'h7F, 1'b1);
      load_reg(8'h01, 1'b0);
      ALU_Sel = 3'd0; Bus1_Sel = 2'd1; Bus2_Sel = 2'd0; A_Load = 1'b1; CCR_Load = 1'b1;
      tick(); idle();
      chk("add_ccr", {4'h0, CCR_Result}, 8'h0A);
      peek("add_A", 2'd1, 8'h80);

      // SUB borrow
      load_reg(8'h00, 1'b1);
      ALU_Sel = 3'd2; Bus1_Sel = 2'd1; Bus2_Sel = 2'd0; A_Load = 1'b1; CCR_Load = 1'b1;
      tick(); idle();
      chk("sub_ccr", {4'h0, CCR_Result}, 8'h09);
      peek("sub_A", 2'd1, 8'hFF);

      // DECB from zero
      load_reg(8'h00, 1'b0);
      ALU_Sel = 3'd6; Bus1_Sel = 2'd2; Bus2_Sel = 2'd0; B_Load = 1'b1; CCR_Load = 1'b1;
      tick(); idle();
      chk("decb_C", {7'h0, CCR_Result[0]}, 8'h01);
      peek("decb_B", 2'd2, 8'hFF);

      // store data path is combinational on Bus1
      load_reg(8'h5A, 1'b0);
      peek("store_to_memory", 2'd2, 8'h5A);

      // PC_Load beats PC_Inc
      Bus2_Sel = 2'd2; from_memory = 8'h40; PC_Load = 1'b1; PC_Inc = 1'b1;
      tick(); idle();
      peek("pc_prio", 2'd0, 8'h40);

      // PC wrap
      Bus2_Sel = 2'd2; from_memory = 8'hFF; PC_Load = 1'b1;
      tick(); idle();
      PC_Inc = 1'b1;
      tick(); idle();
      peek("pc_wrap", 2'd0, 8'h00);

      // load of zero sets Z only
      Bus2_Sel = 2'd2; from_memory = 8'h00; A_Load = 1'b1; CCR_Load = 1'b1;
      tick(); idle();
      chk("ldz_ccr", {4'h0, CCR_Result}, 8'h04);
      peek("ldz_A", 2'd1, 8'h00);

      // several loads capture one Bus2 value
      Bus2_Sel = 2'd2; from_memory = 8'h3C;
      {IR_Load, MAR_Load, A_Load, B_Load} = '1;
      tick(); idle();
      chk("multi_IR", IR, 8'h3C);
      chk("multi_address", address, 8'h3C);
      peek("multi_A", 2'd1, 8'h3C);
      peek("multi_B", 2'd2, 8'h3C);

      // reset mid-instruction wins over loads
      Reset = 1'b1; Bus2_Sel = 2'd2; from_memory = 8'h77;
      {IR_Load, MAR_Load, A_Load, PC_Load, CCR_Load} = '1;
      tick(); idle();
      chk("midrst_IR", IR, 8'h00);
      peek("midrst_A", 2'd1, 8'h00);
      peek("midrst_PC", 2'd0, 8'h00);

      // randomized control sequences against the model
      for (int i = 0; i < 600; i++) begin
         Reset       = ($urandom_range(0, 39) == 0);
         IR_Load     = $urandom_range(0, 3) == 0;
         MAR_Load    = $urandom_range(0, 3) == 0;
         PC_Load     = $urandom_range(0, 5) == 0;
         PC_Inc      = $urandom_range(0, 2) == 0;
         A_Load      = $urandom_range(0, 2) == 0;
         B_Load      = $urandom_range(0, 2) == 0;
         CCR_Load    = $urandom_range(0, 1) == 0;
         ALU_Sel     = 3'($urandom_range(0, 7));
         Bus1_Sel    = 2'($urandom_range(0, 3));
         Bus2_Sel    = 2'($urandom_range(0, 3));
         from_memory = 8'($urandom_range(0, 255));
         tick();
         Reset    = 1'b0;
         Bus1_Sel = 2'($urandom_range(0, 3));
         chk_model($sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
